seq_mult: RTL and testbench
===========================

// Module: seq_mult
// PURPOSE
//  Iterative shift-add multiplier with valid/ready handshakes. Serves the exponentiation
//  datapath (squaring x and x*y steps) in place of a single-cycle 32x32 '*', trading
//  latency for area. Returns the low WIDTH bits of a*b plus an overflow flag.
// PARAMETERS
//  WIDTH       32  operand and product width (bits)
//  EARLY_EXIT  1   1: stop once the remaining multiplier bits are all zero; 0: always WIDTH steps
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-low reset
//  start_valid  in   1      operands a/b valid
//  start_ready  out  1      block idle; can accept operands
//  a            in   WIDTH  multiplicand
//  b            in   WIDTH  multiplier
//  res_valid    out  1      product/overflow valid
//  res_ready    in   1      consumer accepts result
//  product      out  WIDTH  (a*b) mod 2^WIDTH
//  overflow     out  1      1 if a*b >= 2^WIDTH (upper WIDTH bits of full product nonzero)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, res_valid=0, product=0, overflow=0, internal regs
//    cleared. start_ready=1 (decoded from IDLE). Reset mid-operation aborts; no result produced.
//  - States: IDLE, BUSY, DONE. start_ready = (state==IDLE); res_valid = (state==DONE).
//  - IDLE: on start_valid at an edge -> latch mcand={WIDTH'b0,a} (2*WIDTH), mplier=b,
//    acc=0 (2*WIDTH), step=0; go BUSY. No start_valid -> stay.
//  - BUSY, one step per cycle: if mplier[0] acc<=acc+mcand; mcand<=mcand<<1;
//    mplier<=mplier>>1; step<=step+1.
//    Exit to DONE on the step where step==WIDTH-1, or (EARLY_EXIT && (mplier>>1)==0).
//    On exit, product<=low WIDTH bits of final acc; overflow<=|high WIDTH bits of final acc.
//  - Step count N: EARLY_EXIT=0 -> N=WIDTH. EARLY_EXIT=1 -> N=(index of MSB set in b)+1,
//    N=1 when b==0 or b==1.
//  - Latency: operands accepted at edge k -> res_valid high after edge k+N
//    (N BUSY cycles; no extra DONE-entry cycle).
//  - DONE: product/overflow held stable while res_valid=1 && res_ready=0 (any duration).
//    res_valid && res_ready at an edge -> IDLE; start_ready=1 the following cycle.
//    No same-cycle result-retire/new-accept; min issue interval N+2 cycles.
//  - start_valid is ignored in BUSY/DONE; a and b are sampled only at the IDLE accept edge,
//    so changing them afterwards has no effect.
//  - Arithmetic unsigned; acc is 2*WIDTH bits and never wraps, so overflow is exact.
//  - product/overflow registers change only on the BUSY->DONE transition (and on reset).
// TESTING
//  1 a=3, b=5, EARLY_EXIT=1 -> res_valid 3 cycles after accept; product=15, overflow=0.
//  2 a=0xFFFFFFFF, b=2 -> product=0xFFFFFFFE, overflow=1; a=0x10000, b=0x10000
//    -> product=0, overflow=1.
//  3 b=0 (a=0x1234) -> N=1, product=0, overflow=0; EARLY_EXIT=0 with a=7, b=7
//    -> res_valid exactly 32 cycles after accept, product=49.
//  4 Backpressure: hold res_ready=0 for 10 cycles and toggle a/b/start_valid meanwhile
//    -> product, overflow and res_valid stable, start_ready=0; after retire, IDLE next cycle.
//  5 Reset mid-op: drop rst for 1 cycle during BUSY of 0x00FF*0x00FF -> res_valid=0,
//    start_ready=1, outputs 0; the next op 6*7 returns product=42.
//  6 Exp chain: squaring sequence x=3 (3*3, 9*9, 81*81) back-to-back
//    -> products 9, 81, 6561, all with overflow=0.

Source files
------------

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: low WIDTH bits of a*b plus overflow, one partial product per cycle.
// Latency N cycles (N=WIDTH, or MSB index of b + 1 with EARLY_EXIT); result held in DONE until res_ready.
module seq_mult #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SW-1:0]      step_q, step_d;
  logic [WIDTH-1:0]   product_q, product_d;
  logic               overflow_q, overflow_d;
  logic [2*WIDTH-1:0] acc_sum;
  logic               last_step;

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    mplier_d   = mplier_q;
    step_d     = step_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    acc_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    last_step  = (step_q == SW'(WIDTH - 1)) ||
                 (EARLY_EXIT && ((mplier_q >> 1) == '0));

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          step_d   = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + 1'b1;
        // Result registers load straight from this step's sum, so DONE costs no extra cycle.
        if (last_step) begin
          product_d  = acc_sum[WIDTH-1:0];
          overflow_d = |acc_sum[2*WIDTH-1:WIDTH];
          state_d    = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      acc_q      <= '0;
      mplier_q   <= '0;
      step_q     <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      mplier_q   <= mplier_d;
      step_q     <= step_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign product     = product_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: instance 0 uses EARLY_EXIT=1, instance 1 uses EARLY_EXIT=0; both share a/b.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [1:0]  sv, rr;
  logic [1:0]  srdy, rv;
  logic [31:0] prod [2];
  logic        ovf  [2];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(srdy[0]),
    .a(a), .b(b), .res_valid(rv[0]), .res_ready(rr[0]),
    .product(prod[0]), .overflow(ovf[0])
  );

  seq_mult #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut_f (
    .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(srdy[1]),
    .a(a), .b(b), .res_valid(rv[1]), .res_ready(rr[1]),
    .product(prod[1]), .overflow(ovf[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Step count from the operand: fixed WIDTH, or position of b's top set bit plus one.
  function automatic int ref_steps(input int d, input logic [31:0] bb);
    int n;
    if (d == 1) return 32;
    n = 1;
    for (int i = 0; i < 32; i++) if (bb[i]) n = i + 1;
    return n;
  endfunction

  // Drive one operation on instance d, check latency and result, optionally stall, then retire.
  task automatic run_op(input int d, input logic [31:0] aa, input logic [31:0] bb, input int hold);
    logic [63:0] full;
    int          n;
    int          cnt;
    full = {32'b0, aa} * {32'b0, bb};
    n    = ref_steps(d, bb);
    chk("idle_start_ready", 64'(srdy[d]), 64'd1);
    a = aa; b = bb; sv[d] = 1'b1;
    @(posedge clk); #1;
    sv[d] = 1'b0;
    a = $urandom; b = $urandom;
    chk("busy_start_ready", 64'(srdy[d]), 64'd0);
    cnt = 0;
    while (!rv[d] && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", 64'(cnt), 64'(n));
    chk("product", 64'(prod[d]), 64'(full[31:0]));
    chk("overflow", 64'(ovf[d]), 64'(|full[63:32]));
    for (int h = 0; h < hold; h++) begin
      sv[d] = 1'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk("hold_product", 64'(prod[d]), 64'(full[31:0]));
      chk("hold_overflow", 64'(ovf[d]), 64'(|full[63:32]));
      chk("hold_res_valid", 64'(rv[d]), 64'd1);
      chk("hold_start_ready", 64'(srdy[d]), 64'd0);
    end
    sv[d] = 1'b0; rr[d] = 1'b1;
    @(posedge clk); #1;
    rr[d] = 1'b0;
    chk("retire_res_valid", 64'(rv[d]), 64'd0);
    chk("retire_start_ready", 64'(srdy[d]), 64'd1);
  endtask

  initial begin
    logic [31:0] x;
    rst = 1'b0; sv = '0; rr = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_start_ready", 64'(srdy[d]), 64'd1);
      chk("rst_res_valid", 64'(rv[d]), 64'd0);
      chk("rst_product", 64'(prod[d]), 64'd0);
      chk("rst_overflow", 64'(ovf[d]), 64'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(0, 32'd3, 32'd5, 0);
    run_op(0, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(0, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(0, 32'h1234, 32'd0, 0);
    run_op(0, 32'h1234, 32'd1, 0);
    run_op(1, 32'd7, 32'd7, 0);
    run_op(0, 32'hDEAD_BEEF, 32'h8000_0001, 10);

    // Abort a running op with a one-cycle reset pulse.
    a = 32'h00FF; b = 32'h00FF; sv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("abort_res_valid", 64'(rv[0]), 64'd0);
    chk("abort_start_ready", 64'(srdy[0]), 64'd1);
    chk("abort_product", 64'(prod[0]), 64'd0);
    chk("abort_overflow", 64'(ovf[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("abort_no_result", 64'(rv[0]), 64'd0);
    end
    run_op(0, 32'd6, 32'd7, 0);

    // Squaring chain 3 -> 9 -> 81 -> 6561.
    x = 32'd3;
    for (int i = 0; i < 3; i++) begin
      run_op(0, x, x, 0);
      x = x * x;
    end
    chk("chain_final", 64'(prod[0]), 64'd6561);

    for (int i = 0; i < 40; i++)
      run_op(0, $urandom >> $urandom_range(0, 31), $urandom >> $urandom_range(0, 31),
             $urandom_range(0, 3));
    for (int i = 0; i < 12; i++)
      run_op(1, $urandom, $urandom >> $urandom_range(0, 31), $urandom_range(0, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
